memory_arbiter: RTL and testbench

Shares the core's single-ported RAM between instruction fetch and the memory stage of the five-stage pipeline. It accepts a fetch request and a data load/store request, grants one at a time with data priority and a bounded-starvation guarantee for fetch, and drives the RAM port. It returns per-requester hit strobes that the hazard unit uses to stall fetch and the execute/memory latch. It also flags misaligned data accesses so they never reach RAM.

---
 rtl/memory_arbiter.sv | 161 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and
// the data (load/store) stage. Data has priority; fetch is guaranteed a grant
// after at most I_STARVE_MAX consecutive data grants while it waits.
// Handshake: a requester holds its request and address until its hit strobe;
// the RAM holds ram_* stable and completes the access in the cycle ram_ready
// is high. The arbiter returns to IDLE in the cycle after every hit.
module memory_arbiter #(
   parameter int I_STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iread,
   input  logic [31:0] iaddr,
   output logic        ihit,
   output logic [31:0] iload,
   input  logic        dread,
   input  logic [1:0]  dwrite,
   input  logic [1:0]  dsize,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        dfault,
   output logic [31:0] ram_addr,
   output logic        ram_ren,
   output logic        ram_wen,
   output logic [3:0]  ram_wstrb,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   output logic [1:0]  fsm_state
);

   localparam int CW = (I_STARVE_MAX < 1) ? 1 : $clog2(I_STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IBUSY  = 2'd1,
      DBUSY  = 2'd2,
      DFAULT = 2'd3
   } state_t;

   state_t         state, state_next;
   logic [CW-1:0]  starve_cnt;
   logic [31:0]    owner_addr;
   logic [3:0]     wstrb_q;
   logic [31:0]    wdata_q;
   logic           store_q;

   logic           d_req, d_store, d_mis, starve_ok;
   logic           grant_i, grant_d, grant_f;
   logic [1:0]     d_size;
   logic [3:0]     strb_calc;
   logic [31:0]    wdata_calc;
   logic           unused_bits;

   // Fetch addresses are word addresses; the low bits carry no meaning.
   assign unused_bits = ^iaddr[1:0];

   // Request decode, alignment check and IDLE arbitration.
   always_comb begin
      d_store   = (dwrite != 2'b00);
      d_req     = dread | d_store;
      d_size    = d_store ? dwrite : dsize;
      d_mis     = ((d_size == 2'b10) && daddr[0]) ||
                  ((d_size == 2'b11) && (daddr[1:0] != 2'b00));
      starve_ok = (starve_cnt < CW'(I_STARVE_MAX));
      grant_f   = (state == IDLE) && d_req && d_mis;
      grant_d   = (state == IDLE) && d_req && !d_mis && (!iread || starve_ok);
      grant_i   = (state == IDLE) && iread && !grant_f && !grant_d;
      case (dwrite)
         2'b01:   strb_calc = 4'b0001 << daddr[1:0];
         2'b10:   strb_calc = 4'b0011 << daddr[1:0];
         default: strb_calc = 4'b1111;
      endcase
      case (dwrite)
         2'b01:   wdata_calc = {4{dstore[7:0]}};
         2'b10:   wdata_calc = {2{dstore[15:0]}};
         default: wdata_calc = dstore;
      endcase
   end

   // Next-state logic; busy states leave on ram_ready, DFAULT lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_f)      state_next = DFAULT;
            else if (grant_d) state_next = DBUSY;
            else if (grant_i) state_next = IBUSY;
         end
         IBUSY:   if (ram_ready) state_next = IDLE;
         DBUSY:   if (ram_ready) state_next = IDLE;
         DFAULT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Starvation counter and grant-time capture of the RAM request.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         owner_addr <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         store_q    <= 1'b0;
      end else if (grant_d) begin
         if (iread && starve_ok) starve_cnt <= starve_cnt + CW'(1);
         owner_addr <= {daddr[31:2], 2'b00};
         store_q    <= d_store;
         wstrb_q    <= d_store ? strb_calc : 4'b0000;
         if (d_store) wdata_q <= wdata_calc;
      end else if (grant_i) begin
         starve_cnt <= '0;
         owner_addr <= {iaddr[31:2], 2'b00};
         store_q    <= 1'b0;
         wstrb_q    <= 4'b0000;
      end
   end

   // RAM port controls and hit strobes, derived from state and latches only.
   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_wstrb = 4'b0000;
      ihit      = 1'b0;
      dhit      = 1'b0;
      dfault    = 1'b0;
      case (state)
         IBUSY: begin
            ram_ren = 1'b1;
            // A redirected or dropped fetch still lets the RAM finish, silently.
            ihit    = ram_ready && iread && (iaddr[31:2] == owner_addr[31:2]);
         end
         DBUSY: begin
            ram_ren   = !store_q;
            ram_wen   = store_q;
            ram_wstrb = wstrb_q;
            dhit      = ram_ready;
         end
         DFAULT: begin
            dhit   = 1'b1;
            dfault = 1'b1;
         end
         default: ;
      endcase
   end

   assign ram_addr  = owner_addr;
   assign ram_wdata = wdata_q;
   assign iload     = ram_rdata;
   assign dload     = ram_rdata;
   assign fsm_state = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against
// a transaction-level reference model of the arbitration rules.
module tb_memory_arbiter;

   localparam int MAXS   = 4;
   localparam int G_NONE = 0;
   localparam int G_I    = 1;
   localparam int G_D    = 2;
   localparam int G_F    = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        iread, dread, ram_ready;
   logic [31:0] iaddr, daddr, dstore, ram_rdata;
   logic [1:0]  dwrite, dsize;
   logic        ihit, dhit, dfault, ram_ren, ram_wen;
   logic [31:0] iload, dload, ram_addr, ram_wdata;
   logic [3:0]  ram_wstrb;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   int m_starve;
   int got;
   logic [31:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   memory_arbiter #(.I_STARVE_MAX(MAXS)) dut (
      .clk(clk), .rst(rst),
      .iread(iread), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dread(dread), .dwrite(dwrite), .dsize(dsize), .daddr(daddr),
      .dstore(dstore), .dhit(dhit), .dload(dload), .dfault(dfault),
      .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen),
      .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_ready(ram_ready), .fsm_state(fsm_state)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: decide the grant from the current requests and the
   // model's own count of data grants that fetch has waited through.
   task automatic predict(output int g, output logic st, output logic [31:0] a,
                          output logic [31:0] s, output logic [31:0] w);
      int sz;
      bit req, mis;
      st  = (dwrite != 0);
      req = dread || st;
      sz  = st ? int'(dwrite) : int'(dsize);
      mis = (sz == 2 && daddr % 2 != 0) || (sz == 3 && daddr % 4 != 0);
      if (req && mis) g = G_F;
      else if (req && (!iread || m_starve < MAXS)) begin
         g = G_D;
         if (iread && m_starve < MAXS) m_starve++;
      end else if (iread) begin
         g = G_I;
         m_starve = 0;
      end else g = G_NONE;
      a = ((g == G_I) ? iaddr : daddr) & 32'hFFFF_FFFC;
      case (dwrite)
         2'd1: begin s = 32'(1 << (daddr % 4)); w = 32'(dstore[7:0]) * 32'h0101_0101; end
         2'd2: begin s = 32'(3 << (daddr % 4)); w = 32'(dstore[15:0]) * 32'h0001_0001; end
         default: begin s = 32'hF; w = dstore; end
      endcase
   endtask

   // Drive one arbitration round: requests are already on the inputs while
   // the DUT is idle. Returns with the DUT back in IDLE (cycle after the hit).
   task automatic run_txn(input int lat, input logic redirect, input logic [31:0] new_iaddr,
                          output int who);
      int g;
      logic st, rflag;
      logic [31:0] a, s, w, rd;
      predict(g, st, a, s, w);
      rflag = redirect && (g == G_I);
      who = G_NONE;
      #1;
      chk("idle_state", 32'(fsm_state), 0);
      chk("idle_hits", {ihit, dhit, dfault}, 0);
      chk("idle_ramctl", {ram_ren, ram_wen, ram_wstrb}, 0);
      @(posedge clk); #1;
      if (g == G_NONE) return;
      if (g == G_F) begin
         #1;
         chk("fault_flags", {dhit, dfault}, 2'b11);
         chk("fault_noram", {ram_ren, ram_wen, ram_wstrb}, 0);
         who = G_F;
         @(posedge clk); #1;
         return;
      end
      for (int c = 1; c <= lat; c++) begin
         if (rflag && c == 1) iaddr = new_iaddr;
         rd = $urandom;
         ram_rdata = rd;
         ram_ready = (c == lat);
         #1;
         chk("ram_addr", ram_addr, a);
         chk("ram_ren", ram_ren, (g == G_I) || !st);
         chk("ram_wen", ram_wen, (g == G_D) && st);
         if (g == G_D && st) begin
            chk("ram_wstrb", 32'(ram_wstrb), s);
            chk("ram_wdata", ram_wdata, w);
         end
         chk("ihit", ihit, (c == lat) && (g == G_I) && !rflag);
         chk("dhit", dhit, (c == lat) && (g == G_D));
         chk("dfault_busy", dfault, 0);
         if (c == lat) begin
            if (ihit) begin who = G_I; chk("iload", iload, rd); end
            if (dhit) begin who = G_D; chk("dload", dload, rd); end
         end
         @(posedge clk); #1;
         ram_ready = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] e;
      int g;
      logic st;
      logic [31:0] a, s, w;
      rst = 1'b1; iread = 0; iaddr = 0; dread = 0; dwrite = 0; dsize = 0;
      daddr = 0; dstore = 0; ram_rdata = 0; ram_ready = 0; m_starve = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(fsm_state), 0);
      chk("rst_hits", {ihit, dhit, dfault}, 0);
      chk("rst_ramctl", {ram_ren, ram_wen, ram_wstrb}, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
      rst = 1'b0;

      // single fetch, ready one cycle after ren
      iread = 1; iaddr = 32'h104;
      run_txn(2, 0, 0, got);
      chk("fetch_owner", got, G_I);
      iread = 0;

      // ram_ready in IDLE has no effect
      ram_ready = 1; #1;
      chk("stray_ready_hits", {ihit, dhit}, 0);
      @(posedge clk); #1;
      chk("stray_ready_state", 32'(fsm_state), 0);
      ram_ready = 0;

      // byte store at 0x203
      dwrite = 2'd1; daddr = 32'h203; dstore = 32'hAB;
      run_txn(3, 0, 0, got);
      chk("bstore_owner", got, G_D);
      dwrite = 0;

      // misaligned halfword load
      dread = 1; dsize = 2'd2; daddr = 32'h101;
      run_txn(1, 0, 0, got);
      chk("half_fault", got, G_F);
      dread = 0;

      // both requesters held: D D D D I D D D D I
      iread = 1; iaddr = 32'h1000; dread = 1; dsize = 2'd3; daddr = 32'h2000;
      for (int k = 0; k < 10; k++) exp_q.push_back((k % 5 == 4) ? G_I : G_D);
      for (int k = 0; k < 10; k++) begin
         run_txn(1, 0, 0, got);
         e = exp_q.pop_front();
         chk("grant_order", got, e);
         if (got == G_I) iaddr = iaddr + 4;
         else daddr = daddr + 4;
      end
      iread = 0; dread = 0;

      // fetch redirect while busy: no ihit for 0x40, then 0x80 hits
      iread = 1; iaddr = 32'h40;
      run_txn(3, 1, 32'h80, got);
      chk("abandon_no_hit", got, G_NONE);
      run_txn(1, 0, 0, got);
      chk("redirect_hit", got, G_I);
      iread = 0;

      // reset in the middle of a slow data load
      dread = 1; dsize = 2'd3; daddr = 32'h300;
      predict(g, st, a, s, w);
      @(posedge clk); #1;
      chk("pre_rst_ren", ram_ren, 1);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0; dread = 0; m_starve = 0;
      #1;
      chk("midrst_state", 32'(fsm_state), 0);
      chk("midrst_hits", {ihit, dhit, dfault}, 0);
      chk("midrst_ramctl", {ram_ren, ram_wen, ram_wstrb}, 0);
      chk("midrst_addr", ram_addr, 0);
      chk("midrst_wdata", ram_wdata, 0);
      @(posedge clk); #1;

      // randomized traffic
      for (int n = 0; n < 120; n++) begin
         int dsel;
         iread  = 1'($urandom_range(0, 1));
         iaddr  = $urandom;
         dsel   = $urandom_range(0, 3);
         dread  = (dsel == 1 || dsel == 3);
         dwrite = (dsel >= 2) ? 2'($urandom_range(1, 3)) : 2'd0;
         dsize  = 2'($urandom_range(0, 3));
         daddr  = $urandom;
         dstore = $urandom;
         if (!dread && dwrite == 0) iread = 1;
         run_txn($urandom_range(1, 3), ($urandom_range(0, 5) == 0), iaddr ^ 32'h100, got);
      end
      iread = 0; dread = 0; dwrite = 0;
      #1;
      chk("final_state", 32'(fsm_state), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
